score_bcd_accumulator: RTL and testbench
========================================

# score_bcd_accumulator

Maintains the running game score as a 5-digit packed BCD value that drives the seven-segment display controller's `bcd_score` input. The game logic posts binary merge values (tile sums) through a valid/ready handshake. The block converts each value to BCD with a serial double-dabble, then adds it into the score one digit at a time. The visible score updates atomically, saturates at 99999, and can be cleared synchronously for a new game.

## Interface
- `VALUE_W`, default 17: width of the binary addend; the maximum value 131071 fits in 6 BCD digits.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous score/overflow clear; has priority over everything except `rst`.
- `add_valid` in 1: the addend is valid.
- `add_value` in VALUE_W: binary addend, unsigned.
- `add_ready` out 1: the block accepts an addend this cycle. It is combinational: (state == IDLE) && !clear.
- `busy` out 1: high in any state other than IDLE (registered state decode).
- `bcd_score` out 20: packed BCD score, digit 0 in [3:0] and digit 4 in [19:16]. Registered.
- `overflow` out 1: sticky flag, set when any add saturates. Registered.

## Operation
- States are IDLE, CONV, ADD and COMMIT.
- **IDLE:** when `add_valid && add_ready`, the block latches `add_value` into the shift register, zeroes the 6-digit BCD work register and the bit counter, and moves to CONV.
- **CONV:** each cycle performs one double-dabble step:
  - Every work digit ≥ 5 gets +3.
  - The work register then shifts left by 1, taking in the MSB of the shift register.
  - After VALUE_W steps the state moves to ADD with the digit index at 0 and carry at 0.
- **ADD:** each cycle handles one digit i (0..4):
  - s = score_digit[i] + work_digit[i] + carry, computed with 5 bits.
  - If s > 9, the result digit is s − 10 and carry = 1; otherwise the result digit is s and carry = 0.
  - Result digits go to a temporary sum register, not to `bcd_score`.
  - After digit 4 the state moves to COMMIT.
- **COMMIT:** the saturation condition is final carry == 1 or work digit 5 != 0.
  - If it holds: `bcd_score` <= 20'h99999 and `overflow` <= 1.
  - Otherwise: `bcd_score` <= the sum register.
  - The state then returns to IDLE.
- A digit value above 9 is never produced in `bcd_score`. The score is only ever replaced whole, in COMMIT.
- An addend of 0 runs the full sequence and leaves the score unchanged.
- `clear` while in IDLE: `bcd_score` <= 0 and `overflow` <= 0. No addend is accepted that cycle, even if `add_valid` is high.
- `clear` during CONV, ADD or COMMIT: the operation aborts and the state goes to IDLE. `bcd_score` and `overflow` are zeroed, and the aborted addend is discarded and not replayed.
- `rst` asserted in any state (asynchronously):
  - state = IDLE and all counters and work registers = 0.
  - `bcd_score` = 20'h00000 and `overflow` = 0.
  - `busy` = 0; `add_ready` = 1 when `clear` is low.
- `add_value` is sampled only on the accept edge; later changes are ignored.

## Timing
- Call the accept edge E0. CONV occupies edges E1..E(VALUE_W), ADD occupies the next 5 edges, and COMMIT the next edge.
- With VALUE_W=17: CONV is E1..E17, ADD is E18..E22 and COMMIT is E23. The new `bcd_score` is visible after E23, and `add_ready` returns high in the same cycle.
- Earliest next accept is E24, giving a throughput of one add per VALUE_W+7 cycles.
- With `add_valid` held high continuously, consecutive accepts are exactly VALUE_W+7 cycles apart.
- `busy` rises after E0 and falls after COMMIT.
- Between updates, `bcd_score` stays stable for at least VALUE_W+7 cycles, so the display multiplexer never samples a partial value.

## Test plan
- **Reset:** assert `rst` mid-CONV after an accept of 100. Required: `bcd_score` = 00000, `overflow` = 0 and `busy` = 0 immediately (asynchronously); `add_ready` = 1 after release.
- **Basic add and latency:** from 0, add 4 then add 2048. Required: `bcd_score` = 00004 exactly 23 edges after the first accept, then 02052. `add_ready` is low during the operation, and consecutive accepts are 24 cycles apart with `add_valid` held high.
- **Carry chain:** preload the score to 09999 via repeated adds, then add 1. Required: 10000 with no overflow. Then add 131071 to a score of 0. Required: work digit 5 is nonzero, so the score is 99999 and `overflow` = 1.
- **Saturation by carry:** from 99998, add 2. Required: 99999, `overflow` = 1. Then add 0. Required: 99999 with `overflow` still 1.
- **Clear priority:**
  - Assert `clear` together with `add_valid` in IDLE. Required: no accept, score 0.
  - Assert `clear` at E10 of an add of 64. Required: score 00000, IDLE on the next cycle, no later update.
- **Zero addend and input change:** add 0 to 00512. Required: score remains 00512. Change `add_value` after the accept edge. Required: the result uses the latched value.

Source files
------------

// File: rtl/score_bcd_accumulator.sv
// score_bcd_accumulator: running 5-digit BCD score fed by binary addends via serial double-dabble and digit-serial BCD add.
module score_bcd_accumulator #(
  parameter int VALUE_W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               add_valid,
  input  logic [VALUE_W-1:0] add_value,
  output logic               add_ready,
  output logic               busy,
  output logic [19:0]        bcd_score,
  output logic               overflow
);
  localparam int CW = $clog2(VALUE_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, ADD, COMMIT} state_t;
  state_t             r_state, w_next;
  logic [VALUE_W-1:0] r_shift;
  logic [23:0]        r_work, w_adj;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_idx;
  logic               r_carry;
  logic [19:0]        r_sum, r_score;
  logic               r_ovf;
  logic               w_last_bit;
  logic [4:0]         w_s;
  logic [3:0]         w_dig;
  assign add_ready  = (r_state == IDLE) && !clear;
  assign busy       = (r_state != IDLE);
  assign bcd_score  = r_score;
  assign overflow   = r_ovf;
  assign w_last_bit = (r_cnt == CW'(VALUE_W - 1));
  for (genvar d = 0; d < 6; d++) begin : g_adj
    assign w_adj[d*4 +: 4] = (r_work[d*4 +: 4] >= 4'd5) ? r_work[d*4 +: 4] + 4'd3 : r_work[d*4 +: 4];
  end
  assign w_s   = 5'(r_score[{r_idx, 2'b00} +: 4]) + 5'(r_work[{r_idx, 2'b00} +: 4]) + 5'(r_carry);
  assign w_dig = (w_s > 5'd9) ? 4'(w_s - 5'd10) : w_s[3:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = add_valid ? CONV : IDLE;
      CONV:    w_next = w_last_bit ? ADD : CONV;
      ADD:     w_next = (r_idx == 3'd4) ? COMMIT : ADD;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (clear) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_score <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_score <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (add_valid) begin
          r_shift <= add_value;
          r_work  <= '0;
          r_cnt   <= '0;
        end
        CONV: begin
          r_work  <= {w_adj[22:0], r_shift[VALUE_W-1]};
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last_bit) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
          end
        end
        ADD: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_dig;
          r_carry <= (w_s > 5'd9);
          r_idx   <= r_idx + 3'd1;
        end
        COMMIT:
          // a sixth addend digit can never fit in the 5-digit score
          if (r_carry || r_work[23:20] != 4'd0) begin
            r_score <= 20'h99999;
            r_ovf   <= 1'b1;
          end else begin
            r_score <= r_sum;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bcd_accumulator.sv
// tb_score_bcd_accumulator: scoreboard bench; stimulus queues expected score/overflow/latency, a monitor checks each completion.
module tb_score_bcd_accumulator;
  logic        clk = 0, rst = 1, clear = 0, add_valid = 0;
  logic [16:0] add_value = '0;
  logic        add_ready, busy, overflow;
  logic [19:0] bcd_score;
  typedef struct {logic [19:0] s; logic o; int lat;} exp_t;
  exp_t q[$];
  int passed = 0, total = 0, cyc = 0, acc_cyc = 0;
  logic prev_busy = 0;
  score_bcd_accumulator #(.VALUE_W(17)) dut (
    .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid), .add_value(add_value),
    .add_ready(add_ready), .busy(busy), .bcd_score(bcd_score), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  always @(negedge clk) begin
    if (prev_busy && !busy && !rst) begin
      if (q.size() == 0) chk("unexpected_update", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("score", 32'(bcd_score), 32'(e.s));
        chk("overflow", 32'(overflow), 32'(e.o));
        chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
    if (add_valid && add_ready && !rst) acc_cyc = cyc + 1;
    prev_busy = busy;
  end
  task automatic wait_idle();
    int n = 0;
    do @(negedge clk); while (busy && ++n < 60);
    if (busy) chk("idle_timeout", 1, 0);
  endtask
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!add_ready && n < 60) begin @(negedge clk); n++; end
    if (!add_ready) chk("ready_timeout", 0, 1);
  endtask
  task automatic do_add(input logic [16:0] v, input logic [19:0] s, input logic o);
    wait_ready();
    add_valid = 1; add_value = v;
    q.push_back('{s, o, 23});
    @(posedge clk); #1;
    add_valid = 0; add_value = ~v;
    @(negedge clk);
    chk("ready_low", 32'(add_ready), 0);
    wait_idle();
  endtask
  task automatic do_clear();
    @(negedge clk); clear = 1;
    @(negedge clk); clear = 0;
  endtask
  initial begin
    int t1, t2;
    #1;
    chk("rst_score", 32'(bcd_score), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(add_ready), 1);
    // back-to-back accepts with add_valid held high
    wait_ready();
    t1 = cyc;
    add_valid = 1; add_value = 17'd4;
    q.push_back('{20'h00004, 1'b0, 23});
    q.push_back('{20'h02052, 1'b0, 23});
    @(posedge clk); #1;
    add_value = 17'd2048;
    @(negedge clk);
    chk("ready_low_b2b", 32'(add_ready), 0);
    wait_ready();
    t2 = cyc;
    chk("accept_spacing", 32'(t2 - t1), 24);
    @(posedge clk); #1;
    add_valid = 0; add_value = '0;
    wait_idle();
    // async reset mid-conversion
    wait_ready();
    add_valid = 1; add_value = 17'd100;
    @(posedge clk); #1;
    add_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_score", 32'(bcd_score), 0);
    chk("async_rst_ovf", 32'(overflow), 0);
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    #1 chk("ready_after_rst2", 32'(add_ready), 1);
    // carry chain and digit-5 saturation
    do_add(17'd5000, 20'h05000, 1'b0);
    do_add(17'd4999, 20'h09999, 1'b0);
    do_add(17'd1, 20'h10000, 1'b0);
    do_clear();
    chk("clear_score", 32'(bcd_score), 0);
    do_add(17'd131071, 20'h99999, 1'b1);
    do_clear();
    chk("clear_ovf", 32'(overflow), 0);
    // saturation by final carry, overflow sticky across a zero add
    do_add(17'd99998, 20'h99998, 1'b0);
    do_add(17'd2, 20'h99999, 1'b1);
    do_add(17'd0, 20'h99999, 1'b1);
    // clear beats add_valid in IDLE
    @(negedge clk);
    clear = 1; add_valid = 1; add_value = 17'd7;
    #1 chk("clear_ready", 32'(add_ready), 0);
    @(posedge clk); #1;
    chk("clear_no_accept", 32'(busy), 0);
    chk("clear_idle_score", 32'(bcd_score), 0);
    chk("clear_idle_ovf", 32'(overflow), 0);
    clear = 0; add_valid = 0;
    // clear aborts an in-flight add at E10
    do_add(17'd5, 20'h00005, 1'b0);
    wait_ready();
    add_valid = 1; add_value = 17'd64;
    q.push_back('{20'h00000, 1'b0, 10});
    @(posedge clk); #1;
    add_valid = 0;
    repeat (9) @(posedge clk);
    @(negedge clk); clear = 1;
    @(posedge clk); #1; clear = 0;
    chk("abort_idle", 32'(busy), 0);
    repeat (30) @(negedge clk);
    chk("abort_no_update", 32'(bcd_score), 0);
    // zero addend, latched input
    do_add(17'd512, 20'h00512, 1'b0);
    do_add(17'd0, 20'h00512, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
